sensor_sync_ctrl: RTL and testbench
===================================

Name: sensor_sync_ctrl

Overview:
- Closed-loop phase controller for the dual sensor-clock generator (24 MHz clocks derived from a 240 MHz clk).
- Measures the frame-start skew between the two sensor vsync signals in clk cycles.
- Drives the generator's err_ch0/err_ch1 inputs for a duration proportional to the skew. This advances the lagging sensor's clock until both frames start within tolerance.
- Reports lock status, the measured offset and timeout errors.

Parameters:
- CNT_W, 20, width of the skew counter and the offset output.
- TOL, 4, skew in clk cycles at or below which the channels count as aligned.
- GAIN_SHIFT, 4, correction hold cycles = offset << GAIN_SHIFT.
- HOLD_MAX, 65535, saturation limit for correction hold cycles (fits 16 bits).
- SETTLE_FRAMES, 2, vsync0 frame starts to wait after a correction before measuring again.
- LOCK_FRAMES, 4, consecutive in-tolerance measurements required to assert locked.
- TIMEOUT, 1000000, maximum clk cycles between first and second vsync edge; must be below 2^CNT_W.

Ports:
- clk  in  1  240 MHz system clock.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  loop enable; low forces IDLE.
- vsync0  in  1  sensor 0 vsync, asynchronous to clk.
- vsync1  in  1  sensor 1 vsync, asynchronous to clk.
- err_ch0  out  1  to generator; high shortens ch0 clock periods, advancing sensor 0.
- err_ch1  out  1  to generator; high advances sensor 1.
- locked  out  1  channels aligned.
- offset  out  CNT_W  last measured skew magnitude.
- ch1_lags  out  1  sign of last measurement: 1 = vsync1 rose after vsync0.
- offset_valid  out  1  one-cycle strobe when offset and ch1_lags update.
- timeout  out  1  one-cycle strobe when the second edge is not seen within TIMEOUT.

Behaviour:
- Reset (reset_n low, asynchronous): all outputs 0, state IDLE, all counters 0.
- Input conditioning:
  - Each vsync goes through a 2-FF synchronizer, then a rising-edge detector.
  - An edge pulse (rise0/rise1) appears 3 clk after the input rises. The delay is identical on both channels, so the measured skew is unaffected.
- FSM states: IDLE, WAIT_FIRST, MEASURE, CORRECT, SETTLE.
- IDLE:
  - err_ch0 = err_ch1 = 0; lock counter cleared; locked = 0.
  - Leaves to WAIT_FIRST when enable = 1.
- enable low in any state: next cycle goes to IDLE, err outputs drop immediately (registered, 1 clk), locked = 0.
- WAIT_FIRST:
  - rise0 only: record first = 0, skew counter = 1, go to MEASURE.
  - rise1 only: record first = 1, skew counter = 1, go to MEASURE.
  - rise0 and rise1 in the same cycle: offset = 0, ch1_lags = 0, offset_valid pulse, treat as in-tolerance (see below).
- MEASURE:
  - Skew counter increments every cycle, saturating at 2^CNT_W - 1.
  - On the opposite-channel edge: offset = counter value, ch1_lags = (first == 0), offset_valid pulses.
  - A repeat edge on the first channel is ignored.
  - If the counter reaches TIMEOUT first: timeout pulse, locked = 0, lock counter = 0, go to WAIT_FIRST.
- Decision when offset_valid pulses:
  - offset <= TOL: lock counter increments, saturating at LOCK_FRAMES. locked = 1 once the counter equals LOCK_FRAMES. Go to WAIT_FIRST.
  - offset > TOL: lock counter = 0, locked = 0.
    - hold = min(offset << GAIN_SHIFT, HOLD_MAX), computed at width CNT_W + GAIN_SHIFT before the compare.
    - Go to CORRECT.
- CORRECT:
  - Asserts err_ch1 if ch1_lags, else err_ch0. Never both at once.
  - Held for exactly hold cycles, with a registered output rising the first cycle in CORRECT.
  - Then go to SETTLE with err deasserted.
  - vsync edges during CORRECT are ignored.
- SETTLE:
  - Counts rise0 pulses; after SETTLE_FRAMES of them, go to WAIT_FIRST.
  - A measurement never spans a correction.
- Reset mid-CORRECT: err drops asynchronously with reset; the generator FSM returns to its own idle.

Optional Feature:
- Macro: SENSOR_SYNC_STATS_EN.
- Defined: adds output corr_count (16 bits).
  - Increments on each entry to CORRECT, saturating at 0xFFFF.
  - Cleared by reset and by enable going low.
- Not defined: port absent, no counter logic.

Test Plan:
- Reset, enable = 1, vsync1 rises 100 cycles after vsync0 -> offset = 100, ch1_lags = 1, err_ch1 high for exactly 1600 cycles, err_ch0 stays 0.
- vsync0 lags vsync1 by 5000 cycles -> 5000 << 4 = 80000 saturates: err_ch0 high for exactly 65535 cycles, then SETTLE waits 2 vsync0 rises.
- Skew 3 for 4 consecutive frames -> locked rises after the 4th offset_valid; a following skew of 10 -> locked = 0 the same cycle, err_ch1 held for 160 cycles.
- Both vsyncs rise in the same clk -> offset = 0, offset_valid pulses, no err asserted, lock counter increments.
- Only vsync0 toggles -> timeout pulses exactly TIMEOUT cycles after the rise0 pulse, locked = 0, FSM returns to WAIT_FIRST.
- enable dropped mid-CORRECT -> err output 0 within 1 clk, FSM in IDLE; with SENSOR_SYNC_STATS_EN defined, corr_count = 0.

Source files
------------

// File: rtl/sensor_sync_ctrl.sv
// sensor_sync_ctrl: measures vsync0/vsync1 frame-start skew and pulses err_ch0/err_ch1 to pull the sensors into alignment.
// Define SENSOR_SYNC_STATS_EN to add the corr_count output (saturating count of corrections started).
module sensor_sync_ctrl #(
  parameter int CNT_W         = 20,
  parameter int TOL           = 4,
  parameter int GAIN_SHIFT    = 4,
  parameter int HOLD_MAX      = 65535,
  parameter int SETTLE_FRAMES = 2,
  parameter int LOCK_FRAMES   = 4,
  parameter int TIMEOUT       = 1000000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             vsync0,
  input  logic             vsync1,
  output logic             err_ch0,
  output logic             err_ch1,
  output logic             locked,
  output logic [CNT_W-1:0] offset,
  output logic             ch1_lags,
  output logic             offset_valid,
  output logic             timeout
`ifdef SENSOR_SYNC_STATS_EN
  ,
  output logic [15:0]      corr_count
`endif
);

  localparam int HOLD_W   = 16;
  localparam int PROD_W   = CNT_W + GAIN_SHIFT;
  localparam int LOCK_W   = $clog2(LOCK_FRAMES + 1);
  localparam int SETTLE_W = $clog2(SETTLE_FRAMES + 1);

  localparam logic [CNT_W-1:0]    TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]    TOL_C        = CNT_W'(TOL);
  localparam logic [PROD_W-1:0]   HOLD_LIMIT   = PROD_W'(HOLD_MAX);
  localparam logic [LOCK_W-1:0]   LOCK_FULL    = LOCK_W'(LOCK_FRAMES);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST  = SETTLE_W'(SETTLE_FRAMES - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FIRST,
    MEASURE,
    CORRECT,
    SETTLE
  } state_t;

  logic [1:0] vsync_in;
  logic [1:0] rise;
  genvar gi;

  assign vsync_in = {vsync1, vsync0};

  // Identical sync + edge pipeline on both channels keeps the measured skew exact.
  generate
    for (gi = 0; gi < 2; gi++) begin : g_edge
      logic meta_reg;
      logic sync_reg;
      logic prev_reg;
      logic rise_reg;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          meta_reg <= 1'b0;
          sync_reg <= 1'b0;
          prev_reg <= 1'b0;
          rise_reg <= 1'b0;
        end else begin
          meta_reg <= vsync_in[gi];
          sync_reg <= meta_reg;
          prev_reg <= sync_reg;
          rise_reg <= sync_reg & ~prev_reg;
        end
      end

      assign rise[gi] = rise_reg;
    end
  endgenerate

  state_t              state_reg;
  logic                first_ch1_reg;
  logic [CNT_W-1:0]    skew_reg;
  logic [HOLD_W-1:0]   hold_reg;
  logic [LOCK_W-1:0]   lock_cnt_reg;
  logic [SETTLE_W-1:0] settle_cnt_reg;

  logic                meas_hit;
  logic [CNT_W-1:0]    meas_value;
  logic                ch1_lags_next;
  logic                in_tol;
  logic [PROD_W-1:0]   hold_wide;
  logic [HOLD_W-1:0]   hold_next;
  logic [LOCK_W-1:0]   lock_cnt_next;

  always_comb begin
    meas_hit      = 1'b0;
    meas_value    = '0;
    ch1_lags_next = 1'b0;
    if (state_reg == WAIT_FIRST && rise[0] && rise[1]) begin
      meas_hit = 1'b1;
    end else if (state_reg == MEASURE && (first_ch1_reg ? rise[0] : rise[1])) begin
      meas_hit      = 1'b1;
      meas_value    = skew_reg;
      ch1_lags_next = ~first_ch1_reg;
    end
  end

  assign in_tol        = (meas_value <= TOL_C);
  assign hold_wide     = PROD_W'(meas_value) << GAIN_SHIFT;
  assign hold_next     = (hold_wide > HOLD_LIMIT) ? HOLD_W'(HOLD_MAX) : HOLD_W'(hold_wide);
  assign lock_cnt_next = (lock_cnt_reg == LOCK_FULL) ? LOCK_FULL : lock_cnt_reg + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      first_ch1_reg  <= 1'b0;
      skew_reg       <= '0;
      hold_reg       <= '0;
      lock_cnt_reg   <= '0;
      settle_cnt_reg <= '0;
      err_ch0        <= 1'b0;
      err_ch1        <= 1'b0;
      locked         <= 1'b0;
      offset         <= '0;
      ch1_lags       <= 1'b0;
      offset_valid   <= 1'b0;
      timeout        <= 1'b0;
    end else begin
      offset_valid <= 1'b0;
      timeout      <= 1'b0;
      if (!enable) begin
        state_reg    <= IDLE;
        err_ch0      <= 1'b0;
        err_ch1      <= 1'b0;
        locked       <= 1'b0;
        lock_cnt_reg <= '0;
      end else begin
        case (state_reg)
          IDLE: begin
            err_ch0      <= 1'b0;
            err_ch1      <= 1'b0;
            locked       <= 1'b0;
            lock_cnt_reg <= '0;
            state_reg    <= WAIT_FIRST;
          end
          WAIT_FIRST: begin
            if (rise[0] != rise[1]) begin
              first_ch1_reg <= rise[1];
              skew_reg      <= CNT_W'(1);
              state_reg     <= MEASURE;
            end
          end
          MEASURE: begin
            if (!meas_hit) begin
              // Fires on the cycle the counter would reach TIMEOUT.
              if (skew_reg >= TIMEOUT_LAST) begin
                timeout      <= 1'b1;
                locked       <= 1'b0;
                lock_cnt_reg <= '0;
                state_reg    <= WAIT_FIRST;
              end else if (skew_reg != '1) begin
                skew_reg <= skew_reg + 1'b1;
              end
            end
          end
          CORRECT: begin
            if (hold_reg <= HOLD_W'(1)) begin
              err_ch0        <= 1'b0;
              err_ch1        <= 1'b0;
              settle_cnt_reg <= '0;
              state_reg      <= SETTLE;
            end else begin
              hold_reg <= hold_reg - 1'b1;
            end
          end
          SETTLE: begin
            if (rise[0]) begin
              if (settle_cnt_reg >= SETTLE_LAST) begin
                state_reg <= WAIT_FIRST;
              end else begin
                settle_cnt_reg <= settle_cnt_reg + 1'b1;
              end
            end
          end
          default: state_reg <= IDLE;
        endcase

        if (meas_hit) begin
          offset       <= meas_value;
          ch1_lags     <= ch1_lags_next;
          offset_valid <= 1'b1;
          if (in_tol) begin
            lock_cnt_reg <= lock_cnt_next;
            locked       <= (lock_cnt_next == LOCK_FULL);
            state_reg    <= WAIT_FIRST;
          end else begin
            lock_cnt_reg <= '0;
            locked       <= 1'b0;
            hold_reg     <= hold_next;
            err_ch1      <= ch1_lags_next;
            err_ch0      <= ~ch1_lags_next;
            state_reg    <= CORRECT;
          end
        end
      end
    end
  end

`ifdef SENSOR_SYNC_STATS_EN
  logic        corr_start;
  logic [15:0] corr_count_reg;

  assign corr_start = meas_hit && !in_tol;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      corr_count_reg <= '0;
    end else if (!enable) begin
      corr_count_reg <= '0;
    end else if (corr_start && corr_count_reg != 16'hFFFF) begin
      corr_count_reg <= corr_count_reg + 1'b1;
    end
  end

  assign corr_count = corr_count_reg;
`endif

endmodule

// File: tb/tb_sensor_sync_ctrl.sv
// tb_sensor_sync_ctrl: directed and randomized vsync skew frames checked against a frame-level model of the phase loop.
// Build with SENSOR_SYNC_STATS_EN defined to also check corr_count.
module tb_sensor_sync_ctrl;

  localparam int CNT_W         = 20;
  localparam int TOL           = 4;
  localparam int GAIN_SHIFT    = 4;
  localparam int HOLD_MAX      = 3000;
  localparam int SETTLE_FRAMES = 2;
  localparam int LOCK_FRAMES   = 4;
  localparam int TIMEOUT       = 5000;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             enable = 1'b0;
  logic             vsync0 = 1'b0;
  logic             vsync1 = 1'b0;
  logic             err_ch0;
  logic             err_ch1;
  logic             locked;
  logic [CNT_W-1:0] offset;
  logic             ch1_lags;
  logic             offset_valid;
  logic             timeout;
`ifdef SENSOR_SYNC_STATS_EN
  logic [15:0]      corr_count;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int m_lock   = 0;
  int m_corr   = 0;

  always #5 clk = ~clk;

  sensor_sync_ctrl #(
    .CNT_W(CNT_W), .TOL(TOL), .GAIN_SHIFT(GAIN_SHIFT), .HOLD_MAX(HOLD_MAX),
    .SETTLE_FRAMES(SETTLE_FRAMES), .LOCK_FRAMES(LOCK_FRAMES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .vsync0(vsync0),
    .vsync1(vsync1),
    .err_ch0(err_ch0),
    .err_ch1(err_ch1),
    .locked(locked),
    .offset(offset),
    .ch1_lags(ch1_lags),
    .offset_valid(offset_valid),
    .timeout(timeout)
`ifdef SENSOR_SYNC_STATS_EN
    ,
    .corr_count(corr_count)
`endif
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Frame-level loop model: lock streak, hold length, correction count.
  task automatic model_measure(input int skew, output bit exp_lock, output int exp_hold);
    if (skew <= TOL) begin
      if (m_lock < LOCK_FRAMES) m_lock++;
      exp_hold = 0;
    end else begin
      m_lock   = 0;
      exp_hold = skew * (1 << GAIN_SHIFT);
      if (exp_hold > HOLD_MAX) exp_hold = HOLD_MAX;
      if (m_corr < 65535) m_corr++;
    end
    exp_lock = (m_lock == LOCK_FRAMES);
  endtask

  // Leader rises, follower rises skew cycles later; waits (bounded) for offset_valid.
  task automatic launch(input int skew, input bit ch0_late, output bit seen);
    int n;
    @(negedge clk);
    if (skew == 0) begin
      vsync0 = 1'b1;
      vsync1 = 1'b1;
    end else begin
      if (ch0_late) vsync1 = 1'b1; else vsync0 = 1'b1;
      repeat (skew) @(negedge clk);
      if (ch0_late) vsync0 = 1'b1; else vsync1 = 1'b1;
    end
    seen = 1'b0;
    n = 0;
    while (!seen && n < 12) begin
      @(negedge clk);
      n++;
      if (offset_valid) seen = 1'b1;
    end
  endtask

  // One vsync0 rise in SETTLE, then a simultaneous pair whose rise0 must be consumed as the last settle frame.
  task automatic settle_check(input string name);
    int nv;
    int ne;
    nv = 0;
    ne = 0;
    repeat (4) @(negedge clk);
    vsync0 = 1'b1;
    repeat (6) begin @(negedge clk); if (err_ch0 || err_ch1) ne++; end
    vsync0 = 1'b0;
    repeat (6) @(negedge clk);
    vsync0 = 1'b1;
    vsync1 = 1'b1;
    repeat (16) begin
      @(negedge clk);
      if (offset_valid) nv++;
      if (err_ch0 || err_ch1) ne++;
    end
    vsync0 = 1'b0;
    vsync1 = 1'b0;
    chk({name, "_settle_consumed"}, nv, 0);
    chk({name, "_settle_no_err"}, ne, 0);
    repeat (6) @(negedge clk);
  endtask

  task automatic run_frame(input string name, input int skew, input bit ch0_late);
    bit seen;
    bit exp_lock;
    bit exp_ch1;
    int exp_hold;
    int cnt_hi;
    int cnt_other;
    launch(skew, ch0_late, seen);
    chk({name, "_valid"}, seen, 1);
    vsync0 = 1'b0;
    vsync1 = 1'b0;
    if (!seen) return;
    model_measure(skew, exp_lock, exp_hold);
    exp_ch1 = (skew != 0) && !ch0_late;
    chk({name, "_offset"}, offset, skew);
    chk({name, "_ch1_lags"}, ch1_lags, exp_ch1);
    chk({name, "_locked"}, locked, exp_lock);
    cnt_hi = 0;
    cnt_other = 0;
    if (exp_hold > 0) begin
      while ((exp_ch1 ? err_ch1 : err_ch0) && cnt_hi < HOLD_MAX + 20) begin
        cnt_hi++;
        if (exp_ch1 ? err_ch0 : err_ch1) cnt_other++;
        @(negedge clk);
      end
      chk({name, "_hold"}, cnt_hi, exp_hold);
      chk({name, "_other_err"}, cnt_other, 0);
`ifdef SENSOR_SYNC_STATS_EN
      chk({name, "_corr_count"}, corr_count, m_corr);
`endif
      settle_check(name);
    end else begin
      repeat (8) begin
        if (err_ch0 || err_ch1) cnt_other++;
        @(negedge clk);
      end
      chk({name, "_no_err"}, cnt_other, 0);
    end
    $display("frame %s skew=%0d ch0_late=%0d offset=%0d ch1_lags=%0d locked=%0d err_cycles=%0d",
             name, skew, ch0_late, offset, ch1_lags, locked, cnt_hi);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    bit lk;
    int hd;
    int cnt;
    int got;
    int nv;
    int ne;

    repeat (4) @(negedge clk);
    chk("rst_err_ch0", err_ch0, 0);
    chk("rst_err_ch1", err_ch1, 0);
    chk("rst_locked", locked, 0);
    chk("rst_offset", offset, 0);
    chk("rst_valid", offset_valid, 0);
    chk("rst_timeout", timeout, 0);
    reset_n = 1'b1;
    enable  = 1'b1;
    repeat (5) @(negedge clk);

    run_frame("ch1_late_100", 100, 0);
    run_frame("ch0_late_600_sat", 600, 1);
    run_frame("hold_edge_187", 187, 1);
    run_frame("hold_edge_188", 188, 0);
    run_frame("tol_edge_5", 5, 0);
    for (int i = 0; i < 4; i++) run_frame($sformatf("skew3_%0d", i), 3, 0);
    run_frame("after_lock_10", 10, 0);
    run_frame("tol_edge_4", 4, 1);
    for (int i = 0; i < 4; i++) run_frame($sformatf("same_clk_%0d", i), 0, 0);

    // Only vsync0 toggles: counter must not restart on the repeat edge.
    @(negedge clk);
    vsync0 = 1'b1;
    cnt = 0;
    got = 0;
    nv  = 0;
    while (got == 0 && cnt < TIMEOUT + 20) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      if (offset_valid) nv++;
      if (timeout) got = cnt;
      if (cnt == 20) vsync0 = 1'b0;
      if (cnt == 40) vsync0 = 1'b1;
    end
    chk("timeout_latency", got, TIMEOUT + 3);
    chk("timeout_locked", locked, 0);
    chk("timeout_no_valid", nv, 0);
    m_lock = 0;
    @(negedge clk);
    chk("timeout_one_shot", timeout, 0);
    $display("timeout seen after %0d clk from vsync0 rise", got);
    vsync0 = 1'b0;
    repeat (6) @(negedge clk);
    run_frame("post_timeout", 3, 0);

    // enable dropped mid-correction
    launch(100, 0, seen);
    chk("en_valid", seen, 1);
    vsync0 = 1'b0;
    vsync1 = 1'b0;
    model_measure(100, lk, hd);
    repeat (40) @(negedge clk);
    chk("en_err_before", err_ch1, 1);
    enable = 1'b0;
    @(negedge clk);
    chk("en_err_ch1_drop", err_ch1, 0);
    chk("en_err_ch0", err_ch0, 0);
    chk("en_locked", locked, 0);
    m_lock = 0;
    m_corr = 0;
`ifdef SENSOR_SYNC_STATS_EN
    chk("en_corr_count", corr_count, 0);
`endif
    launch(7, 1, seen);
    chk("en_idle_no_valid", seen, 0);
    chk("en_idle_no_err", err_ch0 | err_ch1, 0);
    vsync0 = 1'b0;
    vsync1 = 1'b0;
    $display("enable drop: err_ch0=%0d err_ch1=%0d locked=%0d", err_ch0, err_ch1, locked);
    repeat (6) @(negedge clk);
    enable = 1'b1;
    repeat (4) @(negedge clk);
    run_frame("after_enable", 2, 1);

    // asynchronous reset mid-correction
    launch(50, 1, seen);
    chk("arst_valid", seen, 1);
    vsync0 = 1'b0;
    vsync1 = 1'b0;
    model_measure(50, lk, hd);
    repeat (10) @(negedge clk);
    chk("arst_err_before", err_ch0, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_err_ch0", err_ch0, 0);
    chk("arst_offset", offset, 0);
    chk("arst_locked", locked, 0);
    m_lock = 0;
    m_corr = 0;
    $display("async reset: err_ch0=%0d offset=%0d", err_ch0, offset);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    run_frame("post_reset", 1, 0);

    // randomized frames
    for (int i = 0; i < 12; i++) begin
      int cls;
      int skew;
      bit lead;
      cls  = int'($urandom_range(0, 5));
      lead = bit'($urandom_range(0, 1));
      if (cls <= 2) skew = int'($urandom_range(0, TOL));
      else if (cls <= 4) skew = int'($urandom_range(TOL + 1, 120));
      else skew = int'($urandom_range(150, 250));
      run_frame($sformatf("rand_%0d", i), skew, lead);
    end

    ne = 0;
    repeat (5) begin @(negedge clk); if (err_ch0 && err_ch1) ne++; end
    chk("final_err_exclusive", ne, 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
